// File: rtl/motor_duty_ramp_if.sv
// Speed-command / duty bundle between a speed source (master) and one
// motor_duty_ramp channel (slave).
interface motor_duty_ramp_if;
    logic [10:0] cmd;
    logic        cmd_vld;
    logic [9:0]  duty;
    logic        fwd;
    logic        rev;
    logic        busy;

    modport master (output cmd, cmd_vld, input duty, fwd, rev, busy);
    modport slave  (input cmd, cmd_vld, output duty, fwd, rev, busy);
endinterface

// File: rtl/motor_duty_ramp.sv
// One motor channel: signed speed command -> slew-limited 10-bit duty plus direction pins,
// with ramp-down / dead-time sequencing on reversal. Optional macro: BRAKE_ON_ZERO_EN.
module motor_duty_ramp #(
    parameter int unsigned RAMP_DIV  = 1024,
    parameter int unsigned RAMP_STEP = 16,
    parameter int unsigned DEAD_CYC  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_duty_ramp_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, RDN, DEAD} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(RAMP_DIV - 1);
    localparam logic [15:0] DEAD_LOAD = 16'(DEAD_CYC - 1);
    localparam logic [9:0]  STEP      = 10'(RAMP_STEP);

    state_t      state, state_nxt;
    logic [15:0] presc;
    logic        tick;
    logic [9:0]  tgt_mag;
    logic        tgt_dir;
    logic        cur_dir, cur_dir_nxt;
    logic [15:0] dead_cnt, dead_cnt_nxt;
    logic [9:0]  duty_q, duty_nxt, goal, gap;
    logic        fwd_q, rev_q, fwd_nxt, rev_nxt;
    logic [10:0] cmd_abs;
    logic [9:0]  cmd_mag;

    // -1024 has no positive 11-bit counterpart, so it saturates to 1023.
    always_comb begin
        cmd_abs = bus.cmd[10] ? (~bus.cmd + 11'd1) : bus.cmd;
        cmd_mag = cmd_abs[10] ? 10'd1023 : cmd_abs[9:0];
    end

    assign tick = (presc == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            tgt_mag <= '0;
            tgt_dir <= 1'b0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (bus.cmd_vld) begin
                tgt_mag <= cmd_mag;
                tgt_dir <= bus.cmd[10];
            end
        end
    end

    // Slew target: the commanded magnitude only when driving in the commanded direction.
    always_comb begin
        goal = ((state == RUN || state == RDN) && tgt_dir == cur_dir) ? tgt_mag : 10'd0;
        gap  = '0;
        duty_nxt = duty_q;
        if (tick) begin
            if (duty_q < goal) begin
                gap      = goal - duty_q;
                duty_nxt = (gap <= STEP) ? goal : duty_q + STEP;
            end else if (duty_q > goal) begin
                gap      = duty_q - goal;
                duty_nxt = (gap <= STEP) ? goal : duty_q - STEP;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_nxt    = state;
        cur_dir_nxt  = cur_dir;
        dead_cnt_nxt = dead_cnt;
        fwd_nxt      = 1'b0;
        rev_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (tgt_mag != 10'd0) begin
                    state_nxt   = RUN;
                    cur_dir_nxt = tgt_dir;
                end
            end
            RUN: begin
                if (tgt_dir != cur_dir && tgt_mag != 10'd0)
                    state_nxt = RDN;
                else if (duty_q == 10'd0 && tgt_mag == 10'd0)
                    state_nxt = IDLE;
            end
            RDN: begin
                if (tgt_dir == cur_dir) begin
                    state_nxt = RUN;
                end else if (duty_q == 10'd0) begin
                    state_nxt    = DEAD;
                    dead_cnt_nxt = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (dead_cnt == 16'd0) begin
                    if (tgt_mag != 10'd0) begin
                        state_nxt   = RUN;
                        cur_dir_nxt = tgt_dir;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    dead_cnt_nxt = dead_cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Pins are registered from the next state so they change on the same edge as the state.
        case (state_nxt)
            RUN, RDN: begin
                fwd_nxt = ~cur_dir_nxt;
                rev_nxt = cur_dir_nxt;
            end
            IDLE: begin
`ifdef BRAKE_ON_ZERO_EN
                fwd_nxt = 1'b1;
                rev_nxt = 1'b1;
`else
                fwd_nxt = 1'b0;
                rev_nxt = 1'b0;
`endif
            end
            default: begin
                fwd_nxt = 1'b0;
                rev_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_dir  <= 1'b0;
            dead_cnt <= '0;
            duty_q   <= '0;
            fwd_q    <= 1'b0;
            rev_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_dir  <= cur_dir_nxt;
            dead_cnt <= dead_cnt_nxt;
            duty_q   <= duty_nxt;
            fwd_q    <= fwd_nxt;
            rev_q    <= rev_nxt;
        end
    end

    assign bus.duty = duty_q;
    assign bus.fwd  = fwd_q;
    assign bus.rev  = rev_q;
    assign bus.busy = (duty_q != tgt_mag) || (state == RDN) || (state == DEAD);

endmodule

// File: tb/tb_motor_duty_ramp.sv
// Self-checking bench for motor_duty_ramp: steady-state vector table, hand-written
// reversal/abort/reset sequences, and random commands against a behavioural model.
module tb_motor_duty_ramp;

    localparam int DIV  = 4;
    localparam int STEP = 100;
    localparam int DEAD = 8;
`ifdef BRAKE_ON_ZERO_EN
    localparam bit BRAKE = 1'b1;
`else
    localparam bit BRAKE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    motor_duty_ramp_if bus();
    motor_duty_ramp_if bus_big();

    motor_duty_ramp #(.RAMP_DIV(DIV), .RAMP_STEP(STEP), .DEAD_CYC(DEAD)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    motor_duty_ramp #(.RAMP_DIV(DIV), .RAMP_STEP(1023), .DEAD_CYC(DEAD)) u_dut_big (
        .clk(clk), .rst_n(rst_n), .bus(bus_big));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: signed drive direction, a dead-time countdown and a
    // "winding down for reversal" flag, stepped once per clock edge.
    int m_cnt, m_tgt_mag, m_duty, m_dir, m_dead_left;
    bit m_tgt_neg, m_winding, m_armed;

    task automatic model_reset();
        m_cnt = 0; m_tgt_mag = 0; m_tgt_neg = 0; m_duty = 0;
        m_dir = 0; m_dead_left = 0; m_winding = 0; m_armed = 0;
    endtask

    function automatic int toward(input int d, input int w);
        if (d < w) return (d + STEP > w) ? w : d + STEP;
        return (d - STEP < w) ? w : d - STEP;
    endfunction

    task automatic model_step(input bit vld, input logic [10:0] c);
        bit tick;
        int tsign, want, old, sv;
        logic signed [10:0] cs;
        tick  = (m_cnt == DIV - 1);
        tsign = m_tgt_neg ? -1 : 1;
        m_cnt = tick ? 0 : m_cnt + 1;
        m_armed = 1;
        if (m_dead_left > 0) begin
            m_dead_left--;
            if (m_dead_left == 0 && m_tgt_mag != 0) m_dir = tsign;
        end else if (m_dir == 0) begin
            if (m_tgt_mag != 0) m_dir = tsign;
        end else begin
            want = (tsign == m_dir) ? m_tgt_mag : 0;
            old  = m_duty;
            if (tick) m_duty = toward(m_duty, want);
            if (m_winding) begin
                if (tsign == m_dir) m_winding = 0;
                else if (old == 0) begin
                    m_winding = 0; m_dir = 0; m_dead_left = DEAD;
                end
            end else if (tsign != m_dir && m_tgt_mag != 0) m_winding = 1;
            else if (old == 0 && m_tgt_mag == 0) m_dir = 0;
        end
        if (vld) begin
            cs = c;
            sv = int'(cs);
            m_tgt_mag = (sv < 0) ? -sv : sv;
            if (m_tgt_mag > 1023) m_tgt_mag = 1023;
            m_tgt_neg = (sv < 0);
        end
    endtask

    function automatic int model_out();
        bit f, r, b;
        if (m_dir > 0)            {f, r} = 2'b10;
        else if (m_dir < 0)       {f, r} = 2'b01;
        else if (m_dead_left > 0) {f, r} = 2'b00;
        else                      {f, r} = {2{BRAKE & m_armed}};
        b = (m_duty != m_tgt_mag) || m_winding || (m_dead_left > 0);
        return (m_duty << 3) | (int'(f) << 2) | (int'(r) << 1) | int'(b);
    endfunction

    function automatic int dut_out();
        return (int'(bus.duty) << 3) | (int'(bus.fwd) << 2) | (int'(bus.rev) << 1) | int'(bus.busy);
    endfunction

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cycle(input bit vld, input int c);
        bus.cmd_vld = vld;
        bus.cmd     = 11'(c);
        @(posedge clk);
        model_step(vld, 11'(c));
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        bus.cmd     = '0;
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.cmd_vld = 1'b0; bus.cmd = '0;
        bus_big.cmd_vld = 1'b0; bus_big.cmd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_duty(input int val, input int budget, input string name);
        int n = 0;
        while (int'(bus.duty) != val && n < budget) begin
            cycle(1'b0, 0);
            n++;
        end
        check(name, int'(bus.duty), val);
    endtask

    typedef struct {
        int cmd;
        int settle;
        int duty;
        bit fwd;
        bit rev;
        bit busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int vals[$];
        int times[$];
        int prev, busy_at, busy_200, zero_cnt, fwd_low, min_duty, n;
        int exp_a[3] = '{100, 200, 250};
        int exp_b[6] = '{150, 50, 0, 100, 200, 300};

        vecs[0] = '{250,   40, 250,  1'b1, 1'b0, 1'b0};
        vecs[1] = '{-300,  60, 300,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{400,   60, 400,  1'b1, 1'b0, 1'b0};
        vecs[3] = '{-1024, 100, 1023, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0,     80, 0,    BRAKE, BRAKE, 1'b0};
        vecs[5] = '{1,     20, 1,    1'b1, 1'b0, 1'b0};
        vecs[6] = '{1023,  80, 1023, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{-1,   100, 1,    1'b0, 1'b1, 1'b0};

        // Reset state, then the 1023-step channel saturating in a single tick.
        do_reset();
        check("reset_state", dut_out(), 0);
        bus_big.cmd_vld = 1'b1;
        bus_big.cmd     = 11'h400;
        cycle(1'b0, 0);
        bus_big.cmd_vld = 1'b0;
        bus_big.cmd     = '0;
        n = 0;
        while (bus_big.duty == 10'd0 && n < 20) begin
            cycle(1'b0, 0);
            n++;
        end
        check("big_one_tick", int'(bus_big.duty), 1023);
        check("big_rev", int'({bus_big.fwd, bus_big.rev}), 1);
        repeat (8) cycle(1'b0, 0);
        check("big_no_overflow", int'(bus_big.duty), 1023);

        // Ramp up to +250: three steps four clocks apart, busy drops with the last.
        do_reset();
        cycle(1'b0, 0);
        cycle(1'b1, 250);
        prev = bus.duty; busy_at = -1; busy_200 = -1;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 0);
            if (int'(bus.duty) != prev) begin
                vals.push_back(int'(bus.duty));
                times.push_back(i);
                prev = bus.duty;
            end
            if (bus.duty == 10'd200) busy_200 = bus.busy;
            if (bus.duty == 10'd250 && busy_at < 0) busy_at = bus.busy;
        end
        check("rampA_count", vals.size(), 3);
        for (int k = 0; k < 3; k++)
            check("rampA_value", (k < vals.size()) ? vals[k] : -1, exp_a[k]);
        if (times.size() == 3) begin
            check("rampA_spacing1", times[1] - times[0], 4);
            check("rampA_spacing2", times[2] - times[1], 4);
        end
        check("rampA_fwd", int'({bus.fwd, bus.rev}), 2);
        check("rampA_busy_mid", busy_200, 1);
        check("rampA_busy_done", busy_at, 0);

        // Reverse to -300: ramp down, exactly DEAD clocks with both pins low, ramp up reversed.
        vals.delete();
        cycle(1'b1, -300);
        prev = bus.duty; zero_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            cycle(1'b0, 0);
            if (int'(bus.duty) != prev) begin
                vals.push_back(int'(bus.duty));
                prev = bus.duty;
            end
            if (!bus.fwd && !bus.rev) zero_cnt++;
        end
        check("revB_count", vals.size(), 6);
        for (int k = 0; k < 6; k++)
            check("revB_value", (k < vals.size()) ? vals[k] : -1, exp_b[k]);
        check("revB_dead_clocks", zero_cnt, DEAD);
        check("revB_pins", int'({bus.fwd, bus.rev}), 1);

        // Abort a reversal at duty=150: stays forward, no dead time, ramps to 400.
        do_reset();
        cycle(1'b1, 250);
        wait_duty(250, 40, "abortC_reach_250");
        cycle(1'b1, -300);
        wait_duty(150, 40, "abortC_reach_150");
        cycle(1'b1, 400);
        fwd_low = 0; min_duty = 1023;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 0);
            if (!bus.fwd) fwd_low++;
            if (int'(bus.duty) < min_duty) min_duty = int'(bus.duty);
        end
        check("abortC_fwd_low", fwd_low, 0);
        check("abortC_min_duty", min_duty, 150);
        check("abortC_final", dut_out(), (400 << 3) | 4);

        // Asynchronous reset mid-ramp.
        do_reset();
        cycle(1'b1, 250);
        wait_duty(200, 40, "rstF_reach_200");
        rst_n = 1'b0;
        #1;
        check("rstF_immediate", dut_out(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        check("rstF_hold_pins", int'({bus.fwd, bus.rev}), 0);
        cycle(1'b0, 0);

        // Steady-state table.
        do_reset();
        for (int v = 0; v < 8; v++) begin
            cycle(1'b1, vecs[v].cmd);
            repeat (vecs[v].settle) cycle(1'b0, 0);
            check($sformatf("vec%0d", v), dut_out(),
                  (vecs[v].duty << 3) | (int'(vecs[v].fwd) << 2) |
                  (int'(vecs[v].rev) << 1) | int'(vecs[v].busy));
        end

        // Random commands against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) cycle(1'b1, int'($urandom_range(0, 2047)));
            else cycle(1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
